// File: rtl/bus_ram_pkg.sv
// bus_ram_pkg: shared constants and types for the bus_ram single-port RAM.
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : address width in bits
//   DEPTH      : number of words (2**ADDR_WIDTH)
//   word_t     : one data word
//   addr_t     : one word address
package bus_ram_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/bus_ram_if.sv
// bus_ram_if: host <-> RAM bus bundle.
//   Address   : word address (host -> RAM)
//   ReadWrite : 1 = write (host drives Data), 0 = read (RAM may drive Data)
//   Data      : shared bidirectional data bus, resolved wire
//   DataOe    : RAM drive-enable, lets the host observe when the RAM owns Data
interface bus_ram_if;
  import bus_ram_pkg::*;

  addr_t                 Address;
  logic                  ReadWrite;
  wire  [DATA_WIDTH-1:0] Data;
  logic                  DataOe;

  modport master (output Address, output ReadWrite, inout Data, input DataOe);
  modport slave  (input Address, input ReadWrite, inout Data, output DataOe);
endinterface

// File: rtl/bus_ram_tristate.sv
// bus_ram_tristate: pad driver for the shared data bus.
//   en_i   : drive enable; when low the pad is released to high-Z
//   dout_i : word to drive onto the pad
//   din_o  : whatever is currently on the pad, returned to the core
//   pad_io : the shared data bus
module bus_ram_tristate
  import bus_ram_pkg::*;
(
  input  logic                  en_i,
  input  word_t                 dout_i,
  output word_t                 din_o,
  inout  wire  [DATA_WIDTH-1:0] pad_io
);

  assign pad_io = en_i ? dout_i : {DATA_WIDTH{1'bz}};
  assign din_o  = pad_io;

endmodule

// File: rtl/bus_ram.sv
// bus_ram: 256 x 8 single-port synchronous RAM on a shared tristate bus.
//   Clock : sole clock, all state changes on its rising edge
//   Reset : asynchronous active-high; clears the array, read register, valid
//   bus   : bus_ram_if slave (Address, ReadWrite, Data, DataOe)
// A write edge stores the bus word; a read edge loads the read register and
// sets the valid flag, after which the RAM drives Data until ReadWrite rises.
module bus_ram
  import bus_ram_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  bus_ram_if.slave   bus
);

  word_t mem_q [DEPTH];
  word_t rd_q, rd_d;
  logic  vld_q, vld_d;
  word_t din;
  logic  oe;

  // Next state of the read path; a write cycle keeps the read word but
  // invalidates it so it is only shown again after a fresh read edge.
  always_comb begin
    rd_d  = rd_q;
    vld_d = vld_q;
    if (bus.ReadWrite) begin
      vld_d = 1'b0;
    end else begin
      rd_d  = mem_q[bus.Address];
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.ReadWrite) begin
      mem_q[bus.Address] <= din;
    end
  end

  // Combinational enable: the bus is released the moment ReadWrite rises
  // or Reset asserts, without waiting for a clock edge.
  assign oe         = ~bus.ReadWrite & vld_q & ~Reset;
  assign bus.DataOe = oe;

  bus_ram_tristate u_tristate (
    .en_i   (oe),
    .dout_i (rd_q),
    .din_o  (din),
    .pad_io (bus.Data)
  );

endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: directed self-checking bench for bus_ram.
module tb_bus_ram;
  import bus_ram_pkg::*;

  typedef struct {
    logic  rw;
    addr_t addr;
    word_t wdata;
    word_t exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  tb_en = 1'b0;
  word_t tb_dat = '0;
  int    checks = 0;
  int    failures = 0;
  vec_t  vecs [13];

  bus_ram_if bif ();
  assign bif.Data = tb_en ? tb_dat : {DATA_WIDTH{1'bz}};

  bus_ram dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Set up one bus cycle at the falling edge, then sample 1 ns after the
  // following rising edge.
  task automatic bus_cycle(input logic rw, input addr_t addr, input word_t wd);
    @(negedge clk);
    bif.ReadWrite = rw;
    bif.Address   = addr;
    tb_en         = rw;
    tb_dat        = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic read_expect(input string name, input addr_t addr, input word_t exp);
    bus_cycle(1'b0, addr, '0);
    check({name, "_oe"}, int'(bif.DataOe), 1);
    check(name, int'(bif.Data), int'(exp));
  endtask

  initial begin
    vecs[0]  = '{rw: 1'b0, addr: 8'd0,   wdata: 8'h00, exp: 8'h00};
    vecs[1]  = '{rw: 1'b0, addr: 8'd1,   wdata: 8'h00, exp: 8'h00};
    vecs[2]  = '{rw: 1'b0, addr: 8'd255, wdata: 8'h00, exp: 8'h00};
    vecs[3]  = '{rw: 1'b1, addr: 8'd1,   wdata: 8'h05, exp: 8'h05};
    vecs[4]  = '{rw: 1'b1, addr: 8'd2,   wdata: 8'h01, exp: 8'h01};
    vecs[5]  = '{rw: 1'b0, addr: 8'd1,   wdata: 8'h00, exp: 8'h05};
    vecs[6]  = '{rw: 1'b0, addr: 8'd2,   wdata: 8'h00, exp: 8'h01};
    vecs[7]  = '{rw: 1'b1, addr: 8'd255, wdata: 8'hFF, exp: 8'hFF};
    vecs[8]  = '{rw: 1'b1, addr: 8'd0,   wdata: 8'hA5, exp: 8'hA5};
    vecs[9]  = '{rw: 1'b0, addr: 8'd255, wdata: 8'h00, exp: 8'hFF};
    vecs[10] = '{rw: 1'b0, addr: 8'd0,   wdata: 8'h00, exp: 8'hA5};
    vecs[11] = '{rw: 1'b0, addr: 8'd1,   wdata: 8'h00, exp: 8'h05};
    vecs[12] = '{rw: 1'b0, addr: 8'd2,   wdata: 8'h00, exp: 8'h01};

    bif.ReadWrite = 1'b0;
    bif.Address   = '0;

    // Reset state: RAM must not drive the bus.
    repeat (2) @(posedge clk);
    #1;
    check("reset_oe", int'(bif.DataOe), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_oe", int'(bif.DataOe), 0);

    // Table: reads check the RAM-driven word; writes check that the bus
    // carries the host word untouched (RAM released).
    for (int i = 0; i < 13; i++) begin
      bus_cycle(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_oe", i), int'(bif.DataOe), vecs[i].rw ? 0 : 1);
      check($sformatf("vec%0d_data", i), int'(bif.Data), int'(vecs[i].exp));
    end

    // Hold a read of addr2 across three idle edges.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_oe", k), int'(bif.DataOe), 1);
      check($sformatf("hold%0d_data", k), int'(bif.Data), 8'h01);
    end

    // Read addr1, then raise ReadWrite mid-cycle: bus released at once.
    read_expect("rd1_before", 8'd1, 8'h05);
    @(negedge clk);
    bif.ReadWrite = 1'b1;
    bif.Address   = 8'd1;
    tb_en         = 1'b1;
    tb_dat        = 8'h3C;
    #1;
    check("release_oe", int'(bif.DataOe), 0);
    check("release_data", int'(bif.Data), 8'h3C);
    @(posedge clk);
    #1;
    // Drop ReadWrite before any read edge: stale read word must stay hidden.
    bif.ReadWrite = 1'b0;
    tb_en         = 1'b0;
    #1;
    check("stale_hidden_oe", int'(bif.DataOe), 0);
    read_expect("rd1_after", 8'd1, 8'h3C);

    // Write/read addr7, then asynchronous reset between edges.
    bus_cycle(1'b1, 8'd7, 8'h77);
    read_expect("rd7", 8'd7, 8'h77);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_oe", int'(bif.DataOe), 0);
    @(negedge clk);
    rst = 1'b0;
    read_expect("rd7_cleared", 8'd7, 8'h00);
    read_expect("rd1_cleared", 8'd1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
